// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Counter must hold LAT-1 down to 0; LAT+1 keeps LAT=1 at one bit wide.
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester handshake and memory port bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req;
  logic [1:0]       we;
  logic [WIDTH-1:0] adr0;
  logic [WIDTH-1:0] adr1;
  logic [WIDTH-1:0] wd0;
  logic [WIDTH-1:0] wd1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [WIDTH-1:0] rdata;
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] memadr;
  logic [WIDTH-1:0] memwdata;
  logic [WIDTH-1:0] memdata;

  modport slave (
    input  req, we, adr0, adr1, wd0, wd1, memdata,
    output gnt, done, rdata, memread, memwrite, memadr, memwdata
  );

  modport master (
    output req, we, adr0, adr1, wd0, wd1, memdata,
    input  gnt, done, rdata, memread, memwrite, memadr, memwdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - 2-way one-hot picker; round-robin with MEMARB_RR_EN, else fixed priority
module rr_pick (
  input  logic [1:0] req_i,
`ifdef MEMARB_RR_EN
  input  logic       last_i,
`endif
  output logic [1:0] gnt_o
);

`ifdef MEMARB_RR_EN
  // On a tie the requester that was not granted last wins.
  assign gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
`else
  assign gnt_o[0] = req_i[0];
  assign gnt_o[1] = req_i[1] & ~req_i[0];
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between CPU and loader; MEMARB_RR_EN selects round-robin
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = cnt_width(LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             we_l_q, we_l_d;
  logic [WIDTH-1:0] adr_l_q, adr_l_d;
  logic [WIDTH-1:0] wd_l_q, wd_l_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]       pick_gnt;
  logic [1:0]       gnt_c;
  logic [1:0]       done_c;

`ifdef MEMARB_RR_EN
  logic last_q;

  rr_pick u_pick (
    .req_i  (bus.req),
    .last_i (last_q),
    .gnt_o  (pick_gnt)
  );

  // Reset to "DBG granted last" so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ_DBG;
    end else if (|gnt_c) begin
      last_q <= sel_d;
    end
  end
`else
  rr_pick u_pick (
    .req_i (bus.req),
    .gnt_o (pick_gnt)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= REQ_CPU;
      we_l_q  <= 1'b0;
      adr_l_q <= '0;
      wd_l_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_l_q  <= we_l_d;
      adr_l_q <= adr_l_d;
      wd_l_q  <= wd_l_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_l_d  = we_l_q;
    adr_l_d = adr_l_q;
    wd_l_d  = wd_l_q;
    rdata_d = rdata_q;
    gnt_c   = 2'b00;
    done_c  = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_c   = pick_gnt;
          sel_d   = pick_gnt[REQ_DBG];
          we_l_d  = bus.we[pick_gnt[REQ_DBG]];
          adr_l_d = pick_gnt[REQ_DBG] ? bus.adr1 : bus.adr0;
          wd_l_d  = pick_gnt[REQ_DBG] ? bus.wd1 : bus.wd0;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Memory data is valid in the last strobe cycle only.
        if (cnt_q == '0) begin
          if (!we_l_q) rdata_d = bus.memdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        done_c[sel_q] = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt      = gnt_c;
  assign bus.done     = done_c;
  assign bus.rdata    = rdata_q;
  assign bus.memread  = (state_q == BUSY) && !we_l_q;
  assign bus.memwrite = (state_q == BUSY) && we_l_q;
  assign bus.memadr   = adr_l_q;
  assign bus.memwdata = wd_l_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter (WIDTH=8, LAT=2), honours MEMARB_RR_EN
module tb_mem_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] mem [256];
  int         vectors;
  int         miscompares;

  mem_arbiter_if #(.WIDTH(8)) bus ();

  mem_arbiter #(.WIDTH(8), .LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple memory: combinational read, write on the clock edge while strobed.
  assign bus.memdata = mem[bus.memadr];
  always @(posedge clk) begin
    if (bus.memwrite) mem[bus.memadr] <= bus.memwdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_g;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h30] = 8'h5A;
    mem[8'h40] = 8'hC3;
    reset    = 1'b1;
    bus.req  = 2'b00;
    bus.we   = 2'b00;
    bus.adr0 = 8'h00;
    bus.adr1 = 8'h00;
    bus.wd0  = 8'h00;
    bus.wd1  = 8'h00;
    tick();
    tick();
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_done", bus.done, 2'b00);
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_memread", bus.memread, 1'b0);
    chk("rst_memwrite", bus.memwrite, 1'b0);
    chk("rst_memadr", bus.memadr, 8'h00);
    reset = 1'b0;
    tick();

    // Single read by CPU
    bus.req = 2'b01; bus.we = 2'b00; bus.adr0 = 8'h10;
    #1 chk("rd_gnt_c0", bus.gnt, 2'b01);
    tick(); bus.req = 2'b00;
    chk("rd_memread_c1", bus.memread, 1'b1);
    chk("rd_memwrite_c1", bus.memwrite, 1'b0);
    chk("rd_memadr_c1", bus.memadr, 8'h10);
    chk("rd_gnt_c1", bus.gnt, 2'b00);
    tick();
    chk("rd_memread_c2", bus.memread, 1'b1);
    chk("rd_done_c2", bus.done, 2'b00);
    tick();
    chk("rd_done_c3", bus.done, 2'b01);
    chk("rd_rdata_c3", bus.rdata, 8'hA5);
    chk("rd_memread_c3", bus.memread, 1'b0);
    tick();
    chk("rd_done_c4", bus.done, 2'b00);

    // Single write by loader
    bus.req = 2'b10; bus.we = 2'b10; bus.adr1 = 8'h20; bus.wd1 = 8'h3C;
    #1 chk("wr_gnt_c0", bus.gnt, 2'b10);
    tick(); bus.req = 2'b00; bus.we = 2'b00;
    chk("wr_memwrite_c1", bus.memwrite, 1'b1);
    chk("wr_memread_c1", bus.memread, 1'b0);
    chk("wr_memadr_c1", bus.memadr, 8'h20);
    chk("wr_memwdata_c1", bus.memwdata, 8'h3C);
    tick();
    chk("wr_memwrite_c2", bus.memwrite, 1'b1);
    tick();
    chk("wr_done_c3", bus.done, 2'b10);
    chk("wr_rdata_kept", bus.rdata, 8'hA5);
    chk("wr_memwrite_c3", bus.memwrite, 1'b0);
    chk("wr_mem_content", mem[8'h20], 8'h3C);
    tick();

    // Loader request arrives while CPU read is in flight
    bus.req = 2'b01; bus.adr0 = 8'h30;
    #1 chk("bz_gnt0_c0", bus.gnt, 2'b01);
    tick(); bus.req = 2'b10; bus.adr1 = 8'h40; bus.adr0 = 8'hFF;
    #1 chk("bz_gnt_c1", bus.gnt, 2'b00);
    chk("bz_memadr_c1", bus.memadr, 8'h30);
    tick();
    chk("bz_gnt_c2", bus.gnt, 2'b00);
    tick();
    chk("bz_gnt_c3", bus.gnt, 2'b00);
    chk("bz_done_c3", bus.done, 2'b01);
    chk("bz_rdata_c3", bus.rdata, 8'h5A);
    tick();
    chk("bz_gnt1_c4", bus.gnt, 2'b10);
    tick(); bus.req = 2'b00;
    chk("bz_memadr_c5", bus.memadr, 8'h40);
    chk("bz_memread_c5", bus.memread, 1'b1);
    tick();
    tick();
    chk("bz_done_c7", bus.done, 2'b10);
    chk("bz_rdata_c7", bus.rdata, 8'hC3);
    tick();

    // Contention with both requests held; last grant went to loader
    bus.req = 2'b11; bus.we = 2'b00; bus.adr0 = 8'h10; bus.adr1 = 8'h40;
    for (int i = 0; i < 4; i++) begin
`ifdef MEMARB_RR_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      #1 chk($sformatf("ct_gnt_%0d", i), bus.gnt, exp_g);
      tick();
      chk($sformatf("ct_gap_%0d", i), bus.gnt, 2'b00);
      tick();
      tick();
      chk($sformatf("ct_done_%0d", i), bus.done, exp_g);
      chk($sformatf("ct_rdata_%0d", i), bus.rdata, (exp_g == 2'b01) ? 8'hA5 : 8'hC3);
      tick();
    end
    bus.req = 2'b00;
    tick();

    // Back-to-back CPU reads with address changed right after grant
    bus.req = 2'b01; bus.adr0 = 8'h10;
    #1 chk("bb_gnt_a", bus.gnt, 2'b01);
    tick(); bus.adr0 = 8'h30;
    chk("bb_memadr_a", bus.memadr, 8'h10);
    tick();
    tick();
    chk("bb_done_a", bus.done, 2'b01);
    chk("bb_rdata_a", bus.rdata, 8'hA5);
    tick();
    chk("bb_gnt_b", bus.gnt, 2'b01);
    tick(); bus.req = 2'b00;
    chk("bb_memadr_b", bus.memadr, 8'h30);
    tick();
    tick();
    chk("bb_done_b", bus.done, 2'b01);
    chk("bb_rdata_b", bus.rdata, 8'h5A);
    tick();

    // Reset during a write access
    bus.req = 2'b01; bus.we = 2'b01; bus.adr0 = 8'h50; bus.wd0 = 8'h77;
    #1 chk("rm_gnt_c0", bus.gnt, 2'b01);
    tick(); bus.req = 2'b00; bus.we = 2'b00;
    chk("rm_memwrite_c1", bus.memwrite, 1'b1);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("rm_memread", bus.memread, 1'b0);
    chk("rm_memwrite", bus.memwrite, 1'b0);
    chk("rm_gnt", bus.gnt, 2'b00);
    chk("rm_done", bus.done, 2'b00);
    chk("rm_rdata", bus.rdata, 8'h00);
    chk("rm_memadr", bus.memadr, 8'h00);
    tick();
    chk("rm_no_done", bus.done, 2'b00);
    tick();
    chk("rm_no_done2", bus.done, 2'b00);

    // After reset the CPU wins a tie in either arbitration mode
    bus.req = 2'b11;
    #1 chk("rm_tie_gnt", bus.gnt, 2'b01);
    tick(); bus.req = 2'b00;
    tick();
    tick();
    chk("rm_tie_done", bus.done, 2'b01);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
